// File: rtl/mem_bist_pkg.sv
// Shared types for the memory BIST initiator: FSM state encoding and the
// phase tag recorded with the first failing location.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE_INV,
        ST_READ_INV,
        ST_DRAIN_INV,
        ST_DONE
    } state_e;

    localparam logic PHASE_TRUE = 1'b0;
    localparam logic PHASE_INV  = 1'b1;

endpackage

// File: rtl/mem_bist_checker.sv
// Read-data checker: delays expected value/address/phase by one cycle to meet
// the memory's registered readData, counts mismatches, latches the first one.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               cmp_en_i,
    input  logic [WIDTH-1:0]   expected_i,
    input  logic [WIDTH-1:0]   read_data_i,
    input  logic [DEPTH-1:0]   address_i,
    input  logic               phase_i,
    output logic [DEPTH+1:0]   err_count_o,
    output logic [DEPTH-1:0]   first_fail_addr_o,
    output logic               first_fail_phase_o
);

    localparam int ERR_W = DEPTH + 2;

    logic               valid_q;
    logic [WIDTH-1:0]   exp_q;
    logic [DEPTH-1:0]   addr_q;
    logic               phase_q;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [DEPTH-1:0]   ffa_q, ffa_d;
    logic               ffp_q, ffp_d;
    logic               mismatch;

    assign mismatch = valid_q && (read_data_i != exp_q);

    always_comb begin
        err_d = err_q;
        ffa_d = ffa_q;
        ffp_d = ffp_q;
        if (mismatch) begin
            err_d = err_q + ERR_W'(1);
            // Only the very first mismatch of a run is recorded.
            if (err_q == '0) begin
                ffa_d = addr_q;
                ffp_d = phase_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            valid_q <= 1'b0;
            exp_q   <= '0;
            addr_q  <= '0;
            phase_q <= PHASE_TRUE;
            err_q   <= '0;
            ffa_q   <= '0;
            ffp_q   <= PHASE_TRUE;
        end else begin
            valid_q <= cmp_en_i;
            if (cmp_en_i) begin
                exp_q   <= expected_i;
                addr_q  <= address_i;
                phase_q <= phase_i;
            end
            err_q <= err_d;
            ffa_q <= ffa_d;
            ffp_q <= ffp_d;
        end
    end

    assign err_count_o        = err_q;
    assign first_fail_addr_o  = ffa_q;
    assign first_fail_phase_o = ffp_q;

endmodule

// File: rtl/mem_bist.sv
// Four-phase pattern BIST initiator for one sync_mem port: FSM, address
// counter and seed-XOR pattern generator around the read-data checker.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   seed,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [DEPTH+1:0]   errorCount,
    output logic [DEPTH-1:0]   firstFailAddress,
    output logic               firstFailPhase,
    output logic               writeEnable,
    output logic [WIDTH-1:0]   writeData,
    output logic [DEPTH-1:0]   address,
    input  logic [WIDTH-1:0]   readData
);

    state_e             state_q, state_d;
    logic [DEPTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   seed_q;
    logic               pass_q;
    logic               addr_last;
    logic               accept;
    logic [WIDTH-1:0]   addr_ext;
    logic [WIDTH-1:0]   pattern;
    logic               rd_en;
    logic               phase;
    logic [WIDTH-1:0]   expected;

    assign addr_last = (addr_q == {DEPTH{1'b1}});
    assign accept    = (state_q == ST_IDLE) && start;

    // Address zero-extended or truncated to the data width.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addr_ext
        if (gi < DEPTH) begin : g_bit
            assign addr_ext[gi] = addr_q[gi];
        end else begin : g_zero
            assign addr_ext[gi] = 1'b0;
        end
    end

    assign pattern = addr_ext ^ seed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start)     state_d = ST_WRITE;
            ST_WRITE:     if (addr_last) state_d = ST_READ;
            ST_READ:      if (addr_last) state_d = ST_DRAIN;
            ST_DRAIN:                    state_d = ST_WRITE_INV;
            ST_WRITE_INV: if (addr_last) state_d = ST_READ_INV;
            ST_READ_INV:  if (addr_last) state_d = ST_DRAIN_INV;
            ST_DRAIN_INV:                state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        writeEnable = 1'b0;
        writeData   = '0;
        address     = '0;
        rd_en       = 1'b0;
        phase       = PHASE_TRUE;
        expected    = pattern;
        case (state_q)
            ST_WRITE: begin
                busy        = 1'b1;
                writeEnable = 1'b1;
                writeData   = pattern;
                address     = addr_q;
            end
            ST_READ: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                address = addr_q;
            end
            ST_WRITE_INV: begin
                busy        = 1'b1;
                writeEnable = 1'b1;
                writeData   = ~pattern;
                address     = addr_q;
                phase       = PHASE_INV;
            end
            ST_READ_INV: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                address  = addr_q;
                phase    = PHASE_INV;
                expected = ~pattern;
            end
            ST_DRAIN, ST_DRAIN_INV: begin
                busy    = 1'b1;
                address = addr_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Reads hold the last address into the drain cycle; writes wrap to 0.
    always_comb begin
        addr_d = '0;
        case (state_q)
            ST_WRITE, ST_WRITE_INV: addr_d = addr_last ? '0 : addr_q + DEPTH'(1);
            ST_READ, ST_READ_INV:   addr_d = addr_last ? addr_q : addr_q + DEPTH'(1);
            default:                addr_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            seed_q <= '0;
            pass_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            if (accept) begin
                seed_q <= seed;
                pass_q <= 1'b0;
            end else if (state_q == ST_DONE) begin
                pass_q <= (errorCount == '0);
            end
        end
    end

    assign pass = (state_q == ST_DONE) ? (errorCount == '0) : pass_q;

    mem_bist_checker #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_checker (
        .clock              (clock),
        .reset              (reset),
        .clear_i            (accept),
        .cmp_en_i           (rd_en),
        .expected_i         (expected),
        .read_data_i        (readData),
        .address_i          (address),
        .phase_i            (phase),
        .err_count_o        (errorCount),
        .first_fail_addr_o  (firstFailAddress),
        .first_fail_phase_o (firstFailPhase)
    );

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist: behavioural memory with a read-data fault
// mask, a cycle-position model of the run, and directed scenario checks.
module tb_mem_bist;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;
    localparam int N     = 16;
    localparam int RUN   = 4 * N + 3;

    logic               clock;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   seed;
    logic               busy;
    logic               done;
    logic               pass;
    logic [DEPTH+1:0]   errorCount;
    logic [DEPTH-1:0]   firstFailAddress;
    logic               firstFailPhase;
    logic               writeEnable;
    logic [WIDTH-1:0]   writeData;
    logic [DEPTH-1:0]   address;
    logic [WIDTH-1:0]   readData;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    mem_bist #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .seed             (seed),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .errorCount       (errorCount),
        .firstFailAddress (firstFailAddress),
        .firstFailPhase   (firstFailPhase),
        .writeEnable      (writeEnable),
        .writeData        (writeData),
        .address          (address),
        .readData         (readData)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Behavioural sync_mem with a stuck-at mask on the read path.
    logic [WIDTH-1:0] mem [N];
    logic [WIDTH-1:0] mem_rd = '0;
    logic [WIDTH-1:0] rd_mask = 4'hF;
    initial for (int i = 0; i < N; i++) mem[i] = '0;
    always @(posedge clock) begin
        if (writeEnable) mem[address] <= writeData;
        mem_rd <= mem[address];
    end
    assign readData = mem_rd & rd_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pat(input int a, input logic [3:0] s);
        return 4'(a) ^ s;
    endfunction

    // ---------------- model: position k within the run (0 = idle) -------------
    int          m_k = 0;
    logic [3:0]  m_seed = '0;
    int          m_err = 0, m_ffa = 0, m_ffp = 0;
    bit          m_pass = 0;

    // Errors visible in cycle k: true read of a is counted from N+3+a,
    // inverted read of a from 3N+4+a.
    task automatic model_errs(input int k, output int err, output int ffa, output int ffp);
        logic [3:0] p;
        err = 0; ffa = 0; ffp = 0;
        for (int a = 0; a < N; a++) begin
            p = pat(a, m_seed);
            if (((p & rd_mask) != p) && k >= N + 3 + a) begin
                if (err == 0) begin ffa = a; ffp = 0; end
                err++;
            end
        end
        for (int a = 0; a < N; a++) begin
            p = ~pat(a, m_seed);
            if (((p & rd_mask) != p) && k >= 3 * N + 4 + a) begin
                if (err == 0) begin ffa = a; ffp = 1; end
                err++;
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        if (reset) begin
            m_k = 0; m_err = 0; m_ffa = 0; m_ffp = 0; m_pass = 0;
        end else if (m_k == 0) begin
            if (start) begin
                m_k = 1; m_seed = seed; m_pass = 0;
            end
        end else if (m_k == RUN) begin
            m_k = 0;
        end else begin
            m_k++;
        end
        if (!reset && m_k >= 1) begin
            model_errs(m_k, m_err, m_ffa, m_ffp);
            if (m_k == RUN) m_pass = (m_err == 0);
        end
    end

    function automatic bit exp_we(input int k);
        return (k >= 1 && k <= N) || (k >= 2 * N + 2 && k <= 3 * N + 1);
    endfunction

    function automatic int exp_addr(input int k);
        if (k >= 1 && k <= N)                 return k - 1;
        if (k >= N + 1 && k <= 2 * N)         return k - N - 1;
        if (k == 2 * N + 1 || k == 4 * N + 2) return N - 1;
        if (k >= 2 * N + 2 && k <= 3 * N + 1) return k - 2 * N - 2;
        if (k >= 3 * N + 2 && k <= 4 * N + 1) return k - 3 * N - 2;
        return 0;
    endfunction

    function automatic logic [3:0] exp_wdata(input int k, input logic [3:0] s);
        if (k >= 1 && k <= N)                 return pat(k - 1, s);
        if (k >= 2 * N + 2 && k <= 3 * N + 1) return ~pat(k - 2 * N - 2, s);
        return 4'h0;
    endfunction

    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            chk("busy",  busy,        (m_k >= 1 && m_k <= RUN - 1));
            chk("done",  done,        (m_k == RUN));
            chk("we",    writeEnable, exp_we(m_k));
            chk("addr",  address,     exp_addr(m_k));
            if (exp_we(m_k) || m_k == 0 || m_k == RUN)
                chk("wdata", writeData, exp_wdata(m_k, m_seed));
            chk("errcnt", errorCount,       m_err);
            chk("ffa",    firstFailAddress, m_ffa);
            chk("ffp",    firstFailPhase,   m_ffp);
            chk("pass",   pass,             m_pass);
        end
    end

    // ---------------- directed scenarios ----------------
    int c;

    task automatic run_start(input logic [3:0] s);
        @(negedge clock);
        seed  = s;
        start = 1;
        @(negedge clock);
        start = 0;
        c = 1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            c++;
        end
    endtask

    task automatic wait_done(input string name);
        while (!done && c < 200) step(1);
        chk({name, "_done_cycle"}, c, RUN);
        $display("run %s: done at cycle %0d errorCount=%0d pass=%0b ffa=%0d ffp=%0b",
                 name, c, errorCount, pass, firstFailAddress, firstFailPhase);
    endtask

    int done_q[$];

    initial begin
        reset = 1; start = 0; seed = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err",  errorCount, 0);
        chk("rst_ffa",  firstFailAddress, 0);
        chk("rst_ffp",  firstFailPhase, 0);
        chk("rst_we",   writeEnable, 0);
        chk("rst_wd",   writeData, 0);
        chk("rst_addr", address, 0);
        cmp_en = 1;
        reset  = 0;

        // Fault-free, seed 0: data equals address, single done pulse at 67.
        run_start(4'h0);
        chk("t1_busy_c1", busy, 1);
        for (int i = 0; i < N; i++) begin
            chk("t1_wdata", writeData, i);
            chk("t1_waddr", address, i);
            step(1);
        end
        wait_done("t1");
        chk("t1_pass", pass, 1);
        chk("t1_err", errorCount, 0);
        chk("t1_model_err", m_err, 0);
        step(1);
        chk("t1_done_single", done, 0);

        // Seed A: address 3 -> 9, inverted -> 6.
        run_start(4'hA);
        step(3);
        chk("t2_addr3", address, 3);
        chk("t2_wd_true", writeData, 4'h9);
        step(2 * N + 5 - 4);
        chk("t2_addr3_inv", address, 3);
        chk("t2_wd_inv", writeData, 4'h6);
        wait_done("t2");
        chk("t2_pass", pass, 1);

        // readData bit0 stuck at 0.
        rd_mask = 4'hE;
        run_start(4'h0);
        wait_done("t3");
        chk("t3_err", errorCount, 16);
        chk("t3_model_err", m_err, 16);
        chk("t3_ffa", firstFailAddress, 1);
        chk("t3_ffp", firstFailPhase, 0);
        chk("t3_pass", pass, 0);
        step(2);

        // Reset in cycle 20 (one error already visible), then a clean run.
        run_start(4'h0);
        step(19);
        chk("t4_err_c20", errorCount, 1);
        reset = 1;
        step(1);
        reset = 0;
        chk("t4_busy", busy, 0);
        chk("t4_we", writeEnable, 0);
        chk("t4_err", errorCount, 0);
        chk("t4_done", done, 0);
        step(3);
        rd_mask = 4'hF;
        run_start(4'h5);
        wait_done("t4");
        chk("t4_pass", pass, 1);
        step(2);

        // start held high, toggled while busy: done at 67 and 135 only.
        @(negedge clock);
        seed  = 4'h3;
        start = 1;
        @(negedge clock);
        for (c = 1; c <= 140; c++) begin
            if (done) begin
                done_q.push_back(c);
                $display("run t5: done at cycle %0d errorCount=%0d pass=%0b", c, errorCount, pass);
            end
            if (c == 138) chk("t5_idle_busy", busy, 0);
            if (c >= 80 && c <= 130) start = c[0];
            else if (c >= 135)       start = 0;
            else                     start = 1;
            @(negedge clock);
        end
        chk("t5_done_count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("t5_done0", done_q[0], RUN);
            chk("t5_done1", done_q[1], 2 * RUN + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
